// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencing controller.
package conv_pkg;

    localparam int unsigned CONV_IMG_W_BITS  = 10;
    localparam int unsigned CONV_NUM_STAGES  = 5;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_PRIME = 4'd1,
        ST_RUN   = 4'd2,
        ST_DRAIN = 4'd3,
        ST_DONE  = 4'd4
    } state_e;

endpackage

// File: rtl/conv_vld_pipe.sv
// Valid-bit shift chain that produces the per-stage enables of the conv datapath.
module conv_vld_pipe
    import conv_pkg::*;
#(
    parameter int unsigned NUM_STAGES = CONV_NUM_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic accept,
    input  logic advance,
    output logic en_1,
    output logic en_2,
    output logic en_3,
    output logic en_4,
    output logic en_5,
    output logic v5
);

    logic [NUM_STAGES-1:0] v_q;

    // Chain only moves when the output stage is free or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else if (flush) begin
            v_q <= '0;
        end else if (advance) begin
            v_q <= {v_q[NUM_STAGES-2:0], accept};
        end
    end

    assign en_1 = accept;
    assign en_2 = advance & v_q[0];
    assign en_3 = advance & v_q[1];
    assign en_4 = advance & v_q[2];
    assign en_5 = advance & v_q[3];
    assign v5   = v_q[NUM_STAGES-1];

endmodule

// File: rtl/conv_ctrl.sv
// Frame sequencer for a 5-stage 3x3 conv datapath: window intake, pipeline
// enables with backpressure, output counting and frame completion.
module conv_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W_BITS = CONV_IMG_W_BITS,
    parameter int unsigned NUM_STAGES = CONV_NUM_STAGES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [IMG_W_BITS-1:0] cfg_width,
    input  logic [IMG_W_BITS-1:0] cfg_height,
    input  logic                  win_valid,
    output logic                  win_ready,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  en_1,
    output logic                  en_2,
    output logic                  en_3,
    output logic                  en_4,
    output logic                  en_5,
    output logic [3:0]            state,
    output logic                  busy,
    output logic                  done,
    output logic                  coe_lock
);

    localparam int unsigned CNT_W = 2 * IMG_W_BITS;

    state_e                st_q;
    state_e                st_c;
    logic [IMG_W_BITS-1:0] width_q;
    logic [IMG_W_BITS-1:0] height_q;
    logic [IMG_W_BITS-1:0] col_q;
    logic [IMG_W_BITS-1:0] row_q;
    logic [CNT_W-1:0]      out_cnt_q;
    logic [CNT_W-1:0]      last_idx;
    logic                  v5;
    logic                  advance;
    logic                  accept;
    logic                  out_hs;
    logic                  last_col;
    logic                  last_row;

    // Unused encodings behave as IDLE.
    always_comb begin
        st_c = ST_IDLE;
        case (st_q)
            ST_IDLE, ST_PRIME, ST_RUN, ST_DRAIN, ST_DONE: st_c = st_q;
            default:                                      st_c = ST_IDLE;
        endcase
    end

    assign advance   = !(v5 && !out_ready);
    assign win_ready = (st_c == ST_RUN) && advance;
    assign accept    = win_valid && win_ready;
    assign out_hs    = v5 && out_ready;
    assign last_idx  = CNT_W'(width_q) * CNT_W'(height_q) - CNT_W'(1);
    assign last_col  = (col_q == width_q - IMG_W_BITS'(1));
    assign last_row  = (row_q == height_q - IMG_W_BITS'(1));

    conv_vld_pipe #(
        .NUM_STAGES (NUM_STAGES)
    ) u_vld_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (abort),
        .accept  (accept),
        .advance (advance),
        .en_1    (en_1),
        .en_2    (en_2),
        .en_3    (en_3),
        .en_4    (en_4),
        .en_5    (en_5),
        .v5      (v5)
    );

    // Frame FSM with window (col/row) and output-handshake counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= ST_IDLE;
            width_q   <= '0;
            height_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            out_cnt_q <= '0;
        end else if (abort) begin
            st_q      <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            out_cnt_q <= '0;
        end else begin
            if (out_hs) begin
                out_cnt_q <= out_cnt_q + CNT_W'(1);
            end
            case (st_c)
                ST_IDLE: begin
                    if (start) begin
                        width_q   <= cfg_width;
                        height_q  <= cfg_height;
                        col_q     <= '0;
                        row_q     <= '0;
                        out_cnt_q <= '0;
                        st_q      <= (cfg_width == '0 || cfg_height == '0) ? ST_DONE : ST_PRIME;
                    end
                end
                ST_PRIME: st_q <= ST_RUN;
                ST_RUN: begin
                    if (accept) begin
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                st_q <= ST_DRAIN;
                            end else begin
                                row_q <= row_q + IMG_W_BITS'(1);
                            end
                        end else begin
                            col_q <= col_q + IMG_W_BITS'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_hs && out_last) begin
                        st_q <= ST_DONE;
                    end
                end
                ST_DONE: st_q <= ST_IDLE;
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = v5;
    assign out_last  = v5 && (out_cnt_q == last_idx);
    assign state     = st_c;
    assign busy      = (st_c != ST_IDLE);
    assign done      = (st_c == ST_DONE);
    assign coe_lock  = (st_c == ST_PRIME) || (st_c == ST_RUN) || (st_c == ST_DRAIN);

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed bench for conv_ctrl: timing, backpressure, zero-size, abort and reset.
module tb_conv_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [9:0] cfg_width;
    logic [9:0] cfg_height;
    logic       win_valid;
    logic       win_ready;
    logic       out_ready;
    logic       out_valid;
    logic       out_last;
    logic       en_1, en_2, en_3, en_4, en_5;
    logic [3:0] state;
    logic       busy;
    logic       done;
    logic       coe_lock;

    int n_vec = 0;
    int n_err = 0;

    conv_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .en_1       (en_1),
        .en_2       (en_2),
        .en_3       (en_3),
        .en_4       (en_4),
        .en_5       (en_5),
        .state      (state),
        .busy       (busy),
        .done       (done),
        .coe_lock   (coe_lock)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] all_outs();
        return {win_ready, out_valid, out_last, en_1, en_2, en_3, en_4, en_5,
                busy, done, coe_lock, state};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start in IDLE; returns at the first RUN cycle's falling edge.
    task automatic begin_frame(input logic [9:0] w, input logic [9:0] h);
        cfg_width  = w;
        cfg_height = h;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("prime", 32'({win_ready, coe_lock, state}), 32'({1'b0, 1'b1, 4'd1}));
        @(negedge clk);
    endtask

    task automatic run_count(input int bp_lo, input int bp_hi, input int start_c,
                             output int acc, output int hs, output int last_at,
                             output int done_at);
        acc = 0; hs = 0; last_at = -1; done_at = -1;
        for (int c = 0; c < 80; c++) begin
            out_ready = !(c >= bp_lo && c <= bp_hi);
            start     = (c == start_c);
            if (c == start_c) begin
                cfg_width  = 10'd3;
                cfg_height = 10'd3;
            end
            #1;
            if (c >= bp_lo && c <= bp_hi)
                chk("backpressure", 32'({win_ready, out_valid, en_1, en_2, en_3, en_4, en_5, state}),
                    32'({1'b0, 1'b1, 5'b00000, 4'd2}));
            if (win_valid && win_ready) acc++;
            if (out_valid && out_ready) begin
                hs++;
                if (out_last) last_at = hs;
            end
            if (done) begin
                done_at = c;
                break;
            end
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    logic [11:0] ac, ov, ol, dn, bz, e5;
    int acc, hs, last_at, done_at;
    logic seen;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_width = '0; cfg_height = '0; win_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("reset_outs", 32'(all_outs()), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_outs", 32'(all_outs()), 32'h0);

        // 2x2 frame, continuous input and output
        win_valid = 1'b1;
        begin_frame(10'd2, 10'd2);
        for (int c = 0; c < 12; c++) begin
            #1;
            ac[c] = win_valid & win_ready;
            ov[c] = out_valid;
            ol[c] = out_last;
            dn[c] = done;
            bz[c] = busy;
            e5[c] = en_5;
            @(negedge clk);
        end
        chk("f22_accept", 32'(ac), 32'h00F);
        chk("f22_en5",    32'(e5), 32'h0F0);
        chk("f22_valid",  32'(ov), 32'h1E0);
        chk("f22_last",   32'(ol), 32'h100);
        chk("f22_done",   32'(dn), 32'h200);
        chk("f22_busy",   32'(bz), 32'h3FF);
        chk("f22_idle",   32'(state), 32'd0);

        // 3x3 frame, output stalled for 3 cycles once the pipe is full
        begin_frame(10'd3, 10'd3);
        run_count(5, 7, -1, acc, hs, last_at, done_at);
        chk("bp_accepts", 32'(acc), 32'd9);
        chk("bp_results", 32'(hs), 32'd9);
        chk("bp_last",    32'(last_at), 32'd9);
        chk("bp_done",    32'(done_at > 0), 32'd1);

        // zero-width frame completes without any result
        start = 1'b1; cfg_width = 10'd0; cfg_height = 10'd4;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("zero_done", 32'(all_outs()), 32'({3'b000, 5'b00000, 1'b1, 1'b1, 1'b0, 4'd4}));
        @(negedge clk);
        #1;
        chk("zero_idle", 32'(all_outs()), 32'h0);

        // start during RUN with another size is ignored
        begin_frame(10'd2, 10'd2);
        run_count(-1, -2, 2, acc, hs, last_at, done_at);
        chk("restart_results", 32'(hs), 32'd4);
        chk("restart_last",    32'(last_at), 32'd4);
        chk("restart_done",    32'(done_at > 0), 32'd1);
        chk("restart_idle",    32'(state), 32'd0);

        // abort with three windows in flight
        begin_frame(10'd4, 10'd4);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        win_valid = 1'b0;
        abort     = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_outs", 32'(all_outs()), 32'h0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            seen = seen | done | out_valid;
        end
        chk("abort_quiet", 32'(seen), 32'd0);
        win_valid = 1'b1;
        begin_frame(10'd1, 10'd1);
        run_count(-1, -2, -1, acc, hs, last_at, done_at);
        chk("post_abort_results", 32'(hs), 32'd1);
        chk("post_abort_last",    32'(last_at), 32'd1);

        // reset while draining with a stalled result
        out_ready = 1'b0;
        begin_frame(10'd1, 10'd1);
        repeat (5) @(negedge clk);
        #1;
        chk("drain_hold", 32'({out_valid, busy, coe_lock, state}), 32'({1'b1, 1'b1, 1'b1, 4'd3}));
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'(all_outs()), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        begin_frame(10'd2, 10'd2);
        run_count(-1, -2, -1, acc, hs, last_at, done_at);
        chk("post_reset_results", 32'(hs), 32'd4);
        chk("post_reset_last",    32'(last_at), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_ctrl.md
CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL have parameters: IMG_W_BITS, default 10, frame width/height field width; NUM_STAGES, default 5, depth of the sequenced conv pipeline (fixed at 5 in this release).
REQ-002 SHALL have ports: clk  input  1  clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  input  1  begin frame; abort  input  1  synchronous flush; cfg_width  input  IMG_W_BITS  windows per row; cfg_height  input  IMG_W_BITS  rows per frame.
REQ-004 SHALL have ports: win_valid  input  1  3x3 window present; win_ready  output  1  window accepted this cycle when both high.
REQ-005 SHALL have ports: out_ready  input  1  downstream accepts; out_valid  output  1  conv result valid; out_last  output  1  final result of frame.
REQ-006 SHALL have ports: en_1..en_5  output  1 each  stage enables to conv datapath; state  output  4  controller state; busy  output  1  state not IDLE; done  output  1  one-cycle frame-complete pulse; coe_lock  output  1  coefficient source must hold coe_* stable.

Function
REQ-007 SHALL implement states IDLE=0, PRIME=1, RUN=2, DRAIN=3, DONE=4; other codes unreachable, decode to IDLE.
REQ-008 IDLE: start=1 SHALL latch cfg_width/cfg_height; go to DONE if either is 0, else PRIME; start outside IDLE ignored.
REQ-009 PRIME SHALL last exactly one cycle (datapath coefficient registers capture), win_ready=0, then RUN.
REQ-010 coe_lock SHALL be 1 in PRIME, RUN, DRAIN; 0 otherwise.
REQ-011 Pipeline SHALL track valid bits v1..v5; advance = !(v5 & !out_ready).
REQ-012 win_ready = (state==RUN) & advance; accept = win_valid & win_ready.
REQ-013 en_1 = accept; en_k = advance & v(k-1) for k=2..5; v1<=accept, vk<=v(k-1) only when advance.
REQ-014 out_valid = v5; window accepted at cycle N SHALL yield out_valid at cycle N+5 absent backpressure; throughput 1 window/cycle.
REQ-015 While out_valid & !out_ready all en_* SHALL be 0, all v bits held (datapath output stable).
REQ-016 SHALL count accepted windows by column (0..cfg_width-1, wrap increments row); on accept of window (cfg_width-1, cfg_height-1) go to DRAIN.
REQ-017 SHALL count output handshakes (out_valid & out_ready), 2*IMG_W_BITS wide; out_last = out_valid when count == cfg_width*cfg_height-1.
REQ-018 DRAIN: win_ready=0; on out_valid & out_ready & out_last go to DONE.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE; zero-size frame produces done with no out_valid.
REQ-020 abort=1 in any state SHALL next cycle give IDLE, all v bits 0, counters 0, en_* 0, no done; abort has priority over start.
REQ-021 Simultaneous final accept and output handshake in RUN SHALL be handled without lost counts.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, v1..v5=0, counters and latched cfg=0; outputs: win_ready=0, out_valid=0, out_last=0, en_*=0, state=0, busy=0, done=0, coe_lock=0.
REQ-023 Reset mid-frame SHALL discard in-flight results; first start after release behaves as from power-up.

Structure
REQ-024 State encodings, NUM_STAGES and IMG_W_BITS default SHALL live in shared package conv_pkg.
REQ-025 Valid/enable chain SHALL be one sub-module conv_vld_pipe (inputs accept, advance; outputs en_1..en_5, v5); remainder is the FSM and counters.

Verification
REQ-026 2x2 frame, win_valid held 1, out_ready 1: first accept cycle N -> out_valid at N+5, 4 results, out_last on 4th, done one cycle later, state back to 0.
REQ-027 Full pipeline, out_ready low 3 cycles -> win_ready=0, en_1..en_5=0, out_valid held 1 and conv output unchanged for 3 cycles; no result lost or duplicated.
REQ-028 start with cfg_width=0, cfg_height=4 -> PRIME skipped, done pulse within 2 cycles, out_valid never 1.
REQ-029 start pulsed during RUN with different cfg -> ignored; frame completes with original count.
REQ-030 abort in RUN with 3 windows in flight -> next cycle state=0, out_valid=0, no done; following 1x1 frame yields exactly one result with out_last.
REQ-031 rst_n low mid-DRAIN -> all outputs at REQ-022 values immediately, without clock edge.
